// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: instruction-memory request/ack on one side,
// decode valid/ready plus branch redirect on the other.
interface instruction_fetch_if;
    logic [31:0] imemAddr;
    logic        imemReq;
    logic [31:0] imemRdata;
    logic        imemAck;
    logic [31:0] instruction;
    logic [31:0] pcOut;
    logic        instrValid;
    logic        instrReady;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic [31:0] fetchCount;

    modport master (
        output imemAddr, imemReq, instruction, pcOut, instrValid, fetchCount,
        input  imemRdata, imemAck, instrReady, redirect, redirectTarget
    );

    modport slave (
        input  imemAddr, imemReq, instruction, pcOut, instrValid, fetchCount,
        output imemRdata, imemAck, instrReady, redirect, redirectTarget
    );
endinterface

// File: rtl/instruction_fetch.sv
// Non-pipelined instruction fetch: owns the PC, fetches one word at a time over
// req/ack, hands it to decode over valid/ready, and restarts on redirect.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    instruction_fetch_if.master  bus
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] PC_MASK  = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_RESET = RESET_PC & PC_MASK;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] pc_out_q, pc_out_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] count_q, count_d;

    logic [XLEN-1:0] target_c;

    assign target_c = bus.redirectTarget & PC_MASK;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: redirect outranks every other event, including in IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = REQ;
            REQ:     if (bus.imemAck)    state_d = HOLD;
            HOLD:    if (bus.instrReady) state_d = REQ;
            FLUSH:   state_d = REQ;
            default: state_d = IDLE;
        endcase
        if (bus.redirect) begin
            state_d = FLUSH;
        end
    end

    // Datapath next values; an ack or handshake coinciding with redirect is dropped
    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        count_d  = count_q;
        req_d    = (state_d == REQ);
        if (bus.redirect) begin
            pc_d    = target_c;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                REQ: begin
                    if (bus.imemAck) begin
                        instr_d  = bus.imemRdata;
                        pc_out_d = pc_q;
                        valid_d  = 1'b1;
                    end
                end
                HOLD: begin
                    if (bus.instrReady) begin
                        pc_d    = pc_q + PC_STEP;
                        count_d = count_q + XLEN'(1);
                        valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= PC_RESET;
            req_q    <= 1'b0;
            instr_q  <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            req_q    <= req_d;
            instr_q  <= instr_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
        end
    end

    assign bus.imemAddr    = pc_q;
    assign bus.imemReq     = req_q;
    assign bus.instruction = instr_q;
    assign bus.pcOut       = pc_out_q;
    assign bus.instrValid  = valid_q;
    assign bus.fetchCount  = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios, then a randomized run checked
// against a transaction-level PC/count model and a memory content function.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst;
    logic rst_w;
    int   vectors = 0;
    int   miscompares = 0;

    instruction_fetch_if bus ();
    instruction_fetch_if bus_w ();

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (.clk(clk), .rst(rst), .bus(bus));
    instruction_fetch #(.RESET_PC(32'hFFFF_FFFF)) dut_w (.clk(clk), .rst(rst_w), .bus(bus_w));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.imemAck = 1'b0; bus.imemRdata = '0; bus.instrReady = 1'b0;
        bus.redirect = 1'b0; bus.redirectTarget = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.imemAck = 1'($urandom); bus.imemRdata = $urandom; bus.instrReady = 1'($urandom);
            bus.redirect = 1'($urandom); bus.redirectTarget = $urandom;
            step();
            vectors++; if (bus.imemReq !== 1'b0) begin miscompares++; $display("FAIL reset_req[%0d]: got %b want 0", i, bus.imemReq); end
            vectors++; if (bus.instrValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid[%0d]: got %b want 0", i, bus.instrValid); end
            vectors++; if (bus.instruction !== 32'h0) begin miscompares++; $display("FAIL reset_instr[%0d]: got %h want 0", i, bus.instruction); end
            vectors++; if (bus.fetchCount !== 32'h0) begin miscompares++; $display("FAIL reset_count[%0d]: got %0d want 0", i, bus.fetchCount); end
            vectors++; if (bus.imemAddr !== 32'h0) begin miscompares++; $display("FAIL reset_addr[%0d]: got %h want 0", i, bus.imemAddr); end
            vectors++; if (bus.pcOut !== 32'h0) begin miscompares++; $display("FAIL reset_pcout[%0d]: got %h want 0", i, bus.pcOut); end
        end
        rst = 1'b0;
        idle_inputs();
        step();
        vectors++; if (bus.imemReq !== 1'b1) begin miscompares++; $display("FAIL first_req: got %b want 1", bus.imemReq); end
        vectors++; if (bus.imemAddr !== 32'h0) begin miscompares++; $display("FAIL first_addr: got %h want 0", bus.imemAddr); end
    endtask

    task automatic test_zero_wait_stream();
        logic [31:0] words [3];
        words[0] = 32'h8C01_0004; words[1] = 32'h0022_1820; words[2] = 32'hAC03_0008;
        for (int i = 0; i < 3; i++) begin
            vectors++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'(4 * i)) begin miscompares++; $display("FAIL zw_req[%0d]: got req=%b addr=%h want req=1 addr=%h", i, bus.imemReq, bus.imemAddr, 32'(4 * i)); end
            bus.imemAck = 1'b1; bus.imemRdata = words[i]; bus.instrReady = 1'b1;
            step();
            bus.imemAck = 1'b0;
            vectors++; if (bus.instrValid !== 1'b1 || bus.instruction !== words[i]) begin miscompares++; $display("FAIL zw_word[%0d]: got valid=%b instr=%h want 1/%h", i, bus.instrValid, bus.instruction, words[i]); end
            vectors++; if (bus.pcOut !== 32'(4 * i)) begin miscompares++; $display("FAIL zw_pcout[%0d]: got %h want %h", i, bus.pcOut, 32'(4 * i)); end
            vectors++; if (bus.imemReq !== 1'b0) begin miscompares++; $display("FAIL zw_hold_req[%0d]: got %b want 0", i, bus.imemReq); end
            step();
            vectors++; if (bus.instrValid !== 1'b0 || bus.fetchCount !== 32'(i + 1)) begin miscompares++; $display("FAIL zw_accept[%0d]: got valid=%b count=%0d want 0/%0d", i, bus.instrValid, bus.fetchCount, i + 1); end
        end
        bus.instrReady = 1'b0;
        vectors++; if (bus.fetchCount !== 32'd3 || bus.imemAddr !== 32'hC) begin miscompares++; $display("FAIL zw_end: got count=%0d addr=%h want 3/0000000c", bus.fetchCount, bus.imemAddr); end
    endtask

    task automatic test_wait_stall();
        logic [31:0] w;
        w = 32'h2108_FFFF;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'hC) begin miscompares++; $display("FAIL wait_addr[%0d]: got req=%b addr=%h want 1/0000000c", i, bus.imemReq, bus.imemAddr); end
        end
        bus.imemAck = 1'b1; bus.imemRdata = w;
        step();
        bus.imemAck = 1'b0; bus.imemRdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++; if (bus.instrValid !== 1'b1 || bus.instruction !== w || bus.pcOut !== 32'hC) begin miscompares++; $display("FAIL stall_hold[%0d]: got valid=%b instr=%h pc=%h want 1/%h/0000000c", i, bus.instrValid, bus.instruction, bus.pcOut, w); end
            vectors++; if (bus.fetchCount !== 32'd3 || bus.imemReq !== 1'b0) begin miscompares++; $display("FAIL stall_count[%0d]: got count=%0d req=%b want 3/0", i, bus.fetchCount, bus.imemReq); end
        end
        bus.instrReady = 1'b1;
        step();
        bus.instrReady = 1'b0;
        vectors++; if (bus.fetchCount !== 32'd4 || bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h10) begin miscompares++; $display("FAIL stall_release: got count=%0d req=%b addr=%h want 4/1/00000010", bus.fetchCount, bus.imemReq, bus.imemAddr); end
    endtask

    task automatic test_redirect_ack();
        bus.imemAck = 1'b1; bus.imemRdata = 32'hBAD0_BAD0; bus.redirect = 1'b1; bus.redirectTarget = 32'h0000_0103;
        step();
        idle_inputs();
        vectors++; if (bus.instrValid !== 1'b0 || bus.imemReq !== 1'b0) begin miscompares++; $display("FAIL redir_ack_flush: got valid=%b req=%b want 0/0", bus.instrValid, bus.imemReq); end
        vectors++; if (bus.fetchCount !== 32'd4) begin miscompares++; $display("FAIL redir_ack_count: got %0d want 4", bus.fetchCount); end
        step();
        vectors++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h100 || bus.instrValid !== 1'b0) begin miscompares++; $display("FAIL redir_ack_req: got req=%b addr=%h valid=%b want 1/00000100/0", bus.imemReq, bus.imemAddr, bus.instrValid); end
        bus.imemAck = 1'b1; bus.imemRdata = 32'h1234_5678;
        step();
        bus.imemAck = 1'b0;
        vectors++; if (bus.instrValid !== 1'b1 || bus.pcOut !== 32'h100 || bus.instruction !== 32'h1234_5678) begin miscompares++; $display("FAIL redir_ack_word: got valid=%b pc=%h instr=%h want 1/00000100/12345678", bus.instrValid, bus.pcOut, bus.instruction); end
    endtask

    task automatic test_redirect_hold();
        bus.instrReady = 1'b1; bus.redirect = 1'b1; bus.redirectTarget = 32'h0000_2002;
        step();
        idle_inputs();
        vectors++; if (bus.fetchCount !== 32'd4 || bus.instrValid !== 1'b0 || bus.imemReq !== 1'b0) begin miscompares++; $display("FAIL redir_hold: got count=%0d valid=%b req=%b want 4/0/0", bus.fetchCount, bus.instrValid, bus.imemReq); end
        step();
        vectors++; if (bus.imemReq !== 1'b1 || bus.imemAddr !== 32'h2000) begin miscompares++; $display("FAIL redir_hold_req: got req=%b addr=%h want 1/00002000", bus.imemReq, bus.imemAddr); end
    endtask

    task automatic test_pc_wrap();
        rst_w = 1'b1;
        step();
        vectors++; if (bus_w.imemAddr !== 32'hFFFF_FFFC || bus_w.imemReq !== 1'b0) begin miscompares++; $display("FAIL wrap_reset: got addr=%h req=%b want fffffffc/0", bus_w.imemAddr, bus_w.imemReq); end
        rst_w = 1'b0;
        step();
        vectors++; if (bus_w.imemReq !== 1'b1 || bus_w.imemAddr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_req: got req=%b addr=%h want 1/fffffffc", bus_w.imemReq, bus_w.imemAddr); end
        bus_w.imemAck = 1'b1; bus_w.imemRdata = 32'h0BAD_F00D;
        step();
        bus_w.imemAck = 1'b0;
        vectors++; if (bus_w.instrValid !== 1'b1 || bus_w.pcOut !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_word: got valid=%b pc=%h want 1/fffffffc", bus_w.instrValid, bus_w.pcOut); end
        bus_w.instrReady = 1'b1;
        step();
        bus_w.instrReady = 1'b0;
        vectors++; if (bus_w.imemAddr !== 32'h0 || bus_w.fetchCount !== 32'd1 || bus_w.imemReq !== 1'b1) begin miscompares++; $display("FAIL wrap_next: got addr=%h count=%0d req=%b want 00000000/1/1", bus_w.imemAddr, bus_w.fetchCount, bus_w.imemReq); end
    endtask

    // Transaction-level model: PC advances by 4 per accepted word, jumps on redirect
    task automatic test_random(input logic [31:0] start_pc, input logic [31:0] start_count);
        logic [31:0] mpc, mcount, ack_addr;
        logic        exp_flush, exp_req, exp_word, pending, redir;
        int          wait_left, idle_cycles;
        mpc = start_pc; mcount = start_count; ack_addr = '0;
        exp_flush = 1'b0; exp_req = 1'b0; exp_word = 1'b0; pending = 1'b0;
        wait_left = 0; idle_cycles = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            vectors++; if (bus.imemAddr !== mpc) begin miscompares++; $display("FAIL rnd_addr@%0d: got %h want %h", cyc, bus.imemAddr, mpc); end
            vectors++; if (bus.fetchCount !== mcount) begin miscompares++; $display("FAIL rnd_count@%0d: got %0d want %0d", cyc, bus.fetchCount, mcount); end
            vectors++; if (bus.imemReq === 1'b1 && bus.instrValid === 1'b1) begin miscompares++; $display("FAIL rnd_overlap@%0d: req and valid both 1, want at most one", cyc); end
            if (exp_flush) begin
                vectors++; if (bus.imemReq !== 1'b0 || bus.instrValid !== 1'b0) begin miscompares++; $display("FAIL rnd_flush@%0d: got req=%b valid=%b want 0/0", cyc, bus.imemReq, bus.instrValid); end
            end
            if (exp_req) begin
                vectors++; if (bus.imemReq !== 1'b1) begin miscompares++; $display("FAIL rnd_refetch@%0d: got req=%b want 1", cyc, bus.imemReq); end
            end
            if (exp_word) begin
                vectors++; if (bus.instrValid !== 1'b1 || bus.pcOut !== ack_addr || bus.instruction !== mem_word(ack_addr)) begin miscompares++; $display("FAIL rnd_word@%0d: got valid=%b pc=%h instr=%h want 1/%h/%h", cyc, bus.instrValid, bus.pcOut, bus.instruction, ack_addr, mem_word(ack_addr)); end
            end
            idle_cycles++;
            if (idle_cycles > 100) begin
                miscompares++; vectors++;
                $display("FAIL rnd_progress@%0d: no accept or redirect for %0d cycles, want <= 100", cyc, idle_cycles);
                idle_cycles = 0;
            end

            redir = ($urandom_range(11) == 0);
            bus.redirect = redir;
            bus.redirectTarget = $urandom;
            bus.instrReady = 1'($urandom);
            if (bus.imemReq === 1'b1) begin
                if (!pending) begin
                    pending = 1'b1;
                    wait_left = int'($urandom_range(3));
                end
                if (wait_left == 0) begin
                    bus.imemAck = 1'b1; bus.imemRdata = mem_word(bus.imemAddr); pending = 1'b0;
                end else begin
                    bus.imemAck = 1'b0; bus.imemRdata = $urandom; wait_left--;
                end
            end else begin
                pending = 1'b0;
                bus.imemAck = ($urandom_range(4) == 0);
                bus.imemRdata = $urandom;
            end

            exp_req   = exp_flush && !redir;
            exp_flush = redir;
            exp_word  = (bus.imemReq === 1'b1) && bus.imemAck && !redir;
            ack_addr  = bus.imemAddr;
            if (redir) begin
                mpc = bus.redirectTarget & ~32'h3;
                pending = 1'b0;
                idle_cycles = 0;
            end else if (bus.instrValid === 1'b1 && bus.instrReady) begin
                vectors++; if (bus.pcOut !== mpc || bus.instruction !== mem_word(mpc)) begin miscompares++; $display("FAIL rnd_accept@%0d: got pc=%h instr=%h want %h/%h", cyc, bus.pcOut, bus.instruction, mpc, mem_word(mpc)); end
                mpc = mpc + 32'd4;
                mcount = mcount + 32'd1;
                idle_cycles = 0;
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        rst_w = 1'b1;
        idle_inputs();
        bus_w.imemAck = 1'b0; bus_w.imemRdata = '0; bus_w.instrReady = 1'b0;
        bus_w.redirect = 1'b0; bus_w.redirectTarget = '0;
        test_reset();
        test_zero_wait_stream();
        test_wait_stall();
        test_redirect_ack();
        test_redirect_hold();
        test_random(32'h0000_2000, 32'd4);
        test_pc_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Sequential instruction-fetch unit that produces the 32-bit instruction words consumed by the instruction decoder/control unit. It owns the program counter, reads instruction memory through a request/acknowledge handshake, and presents each word with its PC to the decode stage through a valid/ready handshake. A redirect input, driven by branch resolution, flushes the in-flight fetch and restarts at a new target.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset; bits [1:0] are treated as zero.
- clk  in  1  rising-edge clock; the block's only clock.
- rst  in  1  synchronous, active-high reset.
- imemAddr  out  32  fetch address; always word aligned; equals current PC.
- imemReq  out  1  fetch request; high only in state REQ.
- imemRdata  in  32  instruction word; valid when imemAck=1.
- imemAck  in  1  completes the request for the address presented in the same cycle; ignored when imemReq=0.
- instruction  out  32  registered instruction word to decode.
- pcOut  out  32  address from which `instruction` was fetched.
- instrValid  out  1  `instruction`/`pcOut` hold an unconsumed word.
- instrReady  in  1  decode accepts the word when instrValid=1 and instrReady=1.
- redirect  in  1  one-cycle pulse: abandon current fetch, continue at redirectTarget.
- redirectTarget  in  32  new PC; bits [1:0] masked to zero.
- fetchCount  out  32  number of instructions accepted by decode since reset; wraps modulo 2^32.

## Operation
- Registered state machine: IDLE, REQ, HOLD, FLUSH.
- Reset (rst=1 at an edge): state=IDLE, pc=RESET_PC&~3, imemReq=0, imemAddr=RESET_PC&~3, instruction=32'h0000_0000, pcOut=0, instrValid=0, fetchCount=0. rst overrides all other inputs.
- IDLE -> REQ unconditionally.
- REQ: imemReq=1, imemAddr=pc held stable until ack. On imemAck=1: instruction<=imemRdata, pcOut<=pc, instrValid<=1, -> HOLD. Otherwise remain in REQ; no timeout.
- HOLD: imemReq=0; instruction/pcOut/instrValid stable. On instrReady=1: pc<=pc+4 (32-bit wrap, 0xFFFF_FFFC -> 0x0000_0000), fetchCount<=fetchCount+1, instrValid<=0, -> REQ.
- redirect=1 in any non-IDLE state has highest priority: pc<=redirectTarget&~3, instrValid<=0, -> FLUSH. A simultaneous imemAck discards its data; a simultaneous instrReady handshake does not count (fetchCount unchanged, pc not incremented).
- redirect=1 in IDLE: pc<=redirectTarget&~3, -> FLUSH.
- FLUSH: imemReq=0 for exactly one cycle (memory drops any pending transaction); -> REQ.
- Non-pipelined: at most one outstanding request; no new request while instrValid=1.

## Timing
- Edge E0 (first edge with rst=0): IDLE->REQ; imemReq=1 during the cycle after E0.
- Zero-wait memory (ack in the first REQ cycle): instrValid=1 the cycle after the ack edge; with instrReady held 1, the next REQ follows the next edge. Peak throughput: one instruction per 2 cycles.
- N wait cycles add N cycles per instruction; imemAddr does not change during them.
- Redirect latency: redirect at edge Ek -> FLUSH during cycle k+1 -> imemReq=1 with the new address during cycle k+2.
- imemReq, imemAddr, instrValid, instruction, pcOut, fetchCount depend on registered state only; no combinational path from any input to any output.

## Test plan
- Reset: hold rst 3 cycles with random inputs -> imemReq=0, instrValid=0, instruction=0, fetchCount=0, imemAddr=RESET_PC; first request at RESET_PC one cycle after release.
- Zero-wait stream: memory returns 0x8C01_0004, 0x0022_1820, 0xAC03_0008 with instrReady=1 -> pcOut 0x0, 0x4, 0x8 in order, one word every 2 cycles, fetchCount=3.
- Wait states and stall: ack delayed 3 cycles -> imemAddr stable during the wait; instrReady low 4 cycles in HOLD -> instruction/pcOut unchanged and fetchCount unchanged.
- Redirect with simultaneous ack: redirect to 0x0000_0103 in the ack cycle -> data discarded, instrValid stays 0, one FLUSH cycle, next request at 0x0000_0100.
- Redirect in HOLD with instrReady=1 -> fetchCount not incremented, next request at the target, not at pc+4.
- PC wrap: RESET_PC=0xFFFF_FFFC, one accepted word -> next imemAddr=0x0000_0000, fetchCount=1.
